// File: rtl/dotprod_pkg.sv
// dotprod_pkg: shared constants and scheduler state type
// for the dot-product scheduler and its arbiter.
package dotprod_pkg;

  localparam int VEC_LEN = 8;
  localparam int ELEM_W  = 32;
  localparam int VEC_W   = VEC_LEN * ELEM_W;
  localparam int RES_W   = 64;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    RESP
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
// Ports: req (requests), ptr (last winner), gnt (one-hot grant).
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt
);

  logic            found;
  logic [ID_W-1:0] idx;

  // Search ptr+1, ptr+2, ... with wrap; ptr itself is last.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dotprod_sched.sv
// dotprod_sched: shares one dot-product engine among NUM_REQ
// requesters (req_*), drives the engine (eng_*), returns rsp_*.
module dotprod_sched
  import dotprod_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int START_TO = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*VEC_W-1:0] req_a_i,
  input  logic [NUM_REQ*VEC_W-1:0] req_b_i,
  output logic                     eng_start_o,
  output logic [VEC_W-1:0]         eng_a_o,
  output logic [VEC_W-1:0]         eng_b_o,
  input  logic                     eng_busy_i,
  input  logic [RES_W-1:0]         eng_result_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [ID_W-1:0]          rsp_id_o,
  output logic [RES_W-1:0]         rsp_result_o,
  output logic                     rsp_err_o
);

  localparam int CNT_W = $clog2(START_TO + 1);

  sched_state_e     state_q, state_d;
  logic [ID_W-1:0]  ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]  gid;
  logic [VEC_W-1:0] a_sel, b_sel;
  logic             xfer, tmo, done;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req (req_valid_i),
    .ptr (ptr_q),
    .gnt (gnt)
  );

  // One-hot grant to index and operand slice.
  always_comb begin
    gid   = '0;
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        gid   = ID_W'(i);
        a_sel = req_a_i[i*VEC_W +: VEC_W];
        b_sel = req_b_i[i*VEC_W +: VEC_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    req_ready_o = '0;
    eng_start_o = 1'b0;
    rsp_valid_o = 1'b0;
    xfer        = 1'b0;
    tmo         = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready_o = gnt;
        if (|gnt) begin
          xfer    = 1'b1;
          state_d = START;
        end
      end
      START: begin
        eng_start_o = 1'b1;
        state_d     = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (eng_busy_i) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_W'(START_TO - 1)) begin
          // this cycle is the START_TO-th without busy
          tmo     = 1'b1;
          state_d = RESP;
        end
      end
      WAIT_DONE: begin
        if (!eng_busy_i) begin
          done    = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      ptr_q        <= ID_W'(NUM_REQ - 1);
      cnt_q        <= '0;
      eng_a_o      <= '0;
      eng_b_o      <= '0;
      rsp_id_o     <= '0;
      rsp_result_o <= '0;
      rsp_err_o    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        eng_a_o  <= a_sel;
        eng_b_o  <= b_sel;
        rsp_id_o <= gid;
        ptr_q    <= gid;
      end
      if (state_q == START) begin
        cnt_q <= '0;
      end else if (state_q == WAIT_BUSY && !eng_busy_i) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (tmo) begin
        rsp_result_o <= '0;
        rsp_err_o    <= 1'b1;
      end
      if (done) begin
        rsp_result_o <= eng_result_i;
        rsp_err_o    <= 1'b0;
      end
    end
  end

endmodule
